// File: rtl/dsiq_tx_pacer.sv
// ============================================================================
// dsiq_tx_pacer : TX IQ FIFO read pacer (prefill, paced play, drain, flush).
// Option macro: DSIQ_PACER_UNDERRUN_CNT_EN adds underrun_count[15:0].
// Rev 1.0
// ============================================================================
`default_nettype none

module dsiq_tx_pacer #(
  parameter int FIFO_LENW  = 11,
  parameter int DATA_W     = 36,
  parameter int TAIL_MAX   = 256,
  parameter int FLUSH_IDLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    fifo_tdata,
  input  logic                 fifo_tvalid,
  output logic                 fifo_tready,
  input  logic [FIFO_LENW-1:0] fifo_tlength,
  input  logic                 sample_tick,
  input  logic                 tx_enable,
  input  logic [FIFO_LENW-1:0] prefill_level,
  output logic [DATA_W-1:0]    out_tdata,
  output logic                 out_valid,
  output logic [1:0]           state,
  output logic                 underrun
`ifdef DSIQ_PACER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]          underrun_count
`endif
);

  localparam int                TAIL_W    = $clog2(TAIL_MAX + 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_MAX);
  localparam logic              FLUSH_EN  = (FLUSH_IDLE != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t              state_q;
  logic [TAIL_W-1:0]   tail_q;
  logic [TAIL_W-1:0]   tail_d;
  logic [DATA_W-1:0]   out_tdata_q;
  logic                out_valid_q;
  logic                underrun_q;
  logic                play_pop_w;
  logic                underrun_evt_w;
  logic                start_w;

  always_comb begin
    fifo_tready = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE:    fifo_tready = FLUSH_EN & fifo_tvalid;
        ST_PREFILL: fifo_tready = 1'b0;
        default:    fifo_tready = sample_tick & fifo_tvalid;
      endcase
    end
  end

  // Only pops taken while playing reach the TX chain; flushed words are stale.
  assign play_pop_w     = fifo_tready && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign underrun_evt_w = (state_q == ST_RUN) && tx_enable && sample_tick && !fifo_tvalid;
  assign start_w        = (state_q == ST_IDLE) && tx_enable;
  assign tail_d         = tail_q + TAIL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tail_q      <= '0;
      out_tdata_q <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      out_valid_q <= sample_tick;
      underrun_q  <= underrun_evt_w;
      if (sample_tick) begin
        out_tdata_q <= play_pop_w ? fifo_tdata : '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_w) state_q <= ST_PREFILL;
        end
        ST_PREFILL: begin
          if (!tx_enable) begin
            state_q <= ST_IDLE;
          end else if (fifo_tlength >= prefill_level) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A falling tx_enable wins over an empty FIFO: that is a drain, not an underrun.
          if (!tx_enable) begin
            state_q <= ST_DRAIN;
            tail_q  <= '0;
          end else if (underrun_evt_w) begin
            state_q <= ST_PREFILL;
          end
        end
        default: begin
          if (tx_enable) begin
            state_q <= ST_RUN;
          end else if (sample_tick) begin
            tail_q <= tail_d;
            if (!fifo_tvalid || tail_d == TAIL_LAST) state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DSIQ_PACER_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      urun_cnt_q <= 16'd0;
    end else if (start_w) begin
      urun_cnt_q <= 16'd0;
    end else if (underrun_evt_w && urun_cnt_q != 16'hFFFF) begin
      urun_cnt_q <= urun_cnt_q + 16'd1;
    end
  end

  assign underrun_count = urun_cnt_q;
`endif

  assign out_tdata = out_tdata_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_dsiq_tx_pacer.sv
// ============================================================================
// tb_dsiq_tx_pacer : directed bench for dsiq_tx_pacer with a count-only FIFO model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dsiq_tx_pacer;

  localparam int FIFO_LENW = 11;
  localparam int DATA_W    = 36;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [DATA_W-1:0]    fifo_tdata;
  logic                 fifo_tvalid;
  logic                 fifo_tready;
  logic [FIFO_LENW-1:0] fifo_tlength;
  logic                 sample_tick;
  logic                 tx_enable;
  logic [FIFO_LENW-1:0] prefill_level;
  logic [DATA_W-1:0]    out_tdata;
  logic                 out_valid;
  logic [1:0]           state;
  logic                 underrun;
`ifdef DSIQ_PACER_UNDERRUN_CNT_EN
  logic [15:0]          underrun_count;
`endif

  int          cnt;
  logic [31:0] rd_ptr;
  int          pops;
  logic        pop_w;
  logic [1:0]  st_pre;
  logic [DATA_W-1:0] exp_data;
  int          total;
  int          bad;

  always #5 clk = ~clk;

  assign fifo_tvalid  = (cnt > 0);
  assign fifo_tlength = (cnt > 2047) ? 11'd2047 : 11'(cnt);
  assign fifo_tdata   = {4'h5, rd_ptr};

  dsiq_tx_pacer #(
    .FIFO_LENW (FIFO_LENW),
    .DATA_W    (DATA_W),
    .TAIL_MAX  (256),
    .FLUSH_IDLE(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_tdata   (fifo_tdata),
    .fifo_tvalid  (fifo_tvalid),
    .fifo_tready  (fifo_tready),
    .fifo_tlength (fifo_tlength),
    .sample_tick  (sample_tick),
    .tx_enable    (tx_enable),
    .prefill_level(prefill_level),
    .out_tdata    (out_tdata),
    .out_valid    (out_valid),
    .state        (state),
    .underrun     (underrun)
`ifdef DSIQ_PACER_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  // Called at posedge+1; samples the pop strobe, crosses one edge, updates the FIFO model.
  task automatic cyc();
    #2;
    pop_w    = fifo_tready;
    st_pre   = state;
    exp_data = {4'h5, rd_ptr};
    @(posedge clk);
    #1;
    if (pop_w) begin
      cnt    = cnt - 1;
      rd_ptr = rd_ptr + 32'd1;
      pops   = pops + 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cnt = 300; tx_enable = 1'b0; sample_tick = 1'b0; prefill_level = '0;
    #2;
    total++; if (fifo_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", fifo_tready); end
    cyc();
    cyc();
    total++;
    if (state !== 2'd0 || out_valid !== 1'b0 || underrun !== 1'b0 || out_tdata !== '0) begin
      bad++; $display("FAIL rst_outputs state=%0d valid=%b urun=%b data=%h want 0/0/0/0",
                      state, out_valid, underrun, out_tdata);
    end
    total++; if (cnt !== 300) begin bad++; $display("FAIL rst_nopop cnt=%0d want=300", cnt); end
    rst_n = 1'b1;
    pops = 0;
    for (int i = 0; i < 300; i++) cyc();
    total++; if (pops !== 300) begin bad++; $display("FAIL flush_pops got=%0d want=300", pops); end
    total++;
    if (state !== 2'd0 || out_tdata !== '0) begin
      bad++; $display("FAIL flush_state state=%0d data=%h want 0/0", state, out_tdata);
    end
  endtask

  task automatic test_prefill();
    int errs;
    errs = 0;
    cnt = 0; prefill_level = 11'd100; tx_enable = 1'b1;
    cyc();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL enter_prefill state=%0d want=1", state); end
    for (int i = 0; i < 100; i++) begin
      cnt = i;
      cyc();
      if (state !== 2'd1) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL prefill_hold errors=%0d want=0", errs); end
    cnt = 100;
    cyc();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL prefill_to_run state=%0d want=2", state); end
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_tdata !== exp_data || cnt !== 99) begin
      bad++; $display("FAIL first_tick valid=%b data=%h cnt=%0d want 1/%h/99", out_valid, out_tdata, cnt, exp_data);
    end
    cyc();
    total++;
    if (out_valid !== 1'b0 || out_tdata !== {4'h5, rd_ptr - 32'd1}) begin
      bad++; $display("FAIL hold_between valid=%b data=%h want 0/%h", out_valid, out_tdata, {4'h5, rd_ptr - 32'd1});
    end
  endtask

  task automatic test_underrun();
    cnt = 0; sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    total++;
    if (underrun !== 1'b1 || out_tdata !== '0 || state !== 2'd1) begin
      bad++; $display("FAIL underrun_pulse urun=%b data=%h state=%0d want 1/0/1", underrun, out_tdata, state);
    end
`ifdef DSIQ_PACER_UNDERRUN_CNT_EN
    total++; if (underrun_count !== 16'd1) begin bad++; $display("FAIL underrun_cnt got=%0d want=1", underrun_count); end
`endif
    cyc();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_width got=%b want=0", underrun); end
  endtask

  task automatic test_drain_tail();
    int  dp;
    logic urun_seen;
    dp = 0; urun_seen = 1'b0;
    cnt = 1000;
    cyc();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL tail_run state=%0d want=2", state); end
    tx_enable = 1'b0;
    cyc();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL tail_drain state=%0d want=3", state); end
    sample_tick = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (pop_w && st_pre == 2'd3) dp++;
      if (underrun) urun_seen = 1'b1;
      if (state == 2'd0) break;
    end
    sample_tick = 1'b0;
    total++; if (dp !== 256) begin bad++; $display("FAIL tail_pops got=%0d want=256", dp); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL tail_idle state=%0d want=0", state); end
    total++; if (urun_seen !== 1'b0) begin bad++; $display("FAIL tail_nourun got=%b want=0", urun_seen); end
    cnt = 0;
  endtask

  task automatic test_drain_empty();
    logic urun_seen;
    urun_seen = 1'b0;
    tx_enable = 1'b1; prefill_level = 11'd5;
    cyc();
    cnt = 10;
    cyc();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL de_run state=%0d want=2", state); end
    tx_enable = 1'b0;
    cyc();
    pops = 0; sample_tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (underrun) urun_seen = 1'b1;
    end
    total++;
    if (pops !== 10 || state !== 2'd3) begin
      bad++; $display("FAIL de_pops pops=%0d state=%0d want 10/3", pops, state);
    end
    cyc();
    if (underrun) urun_seen = 1'b1;
    sample_tick = 1'b0;
    total++;
    if (state !== 2'd0 || urun_seen !== 1'b0 || out_tdata !== '0) begin
      bad++; $display("FAIL de_idle state=%0d urun=%b data=%h want 0/0/0", state, urun_seen, out_tdata);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    errs = 0;
    tx_enable = 1'b1; cnt = 0;
    cyc();
    prefill_level = 11'd10; cnt = 20;
    cyc();
    tx_enable = 1'b0;
    cyc();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL b2b_drain state=%0d want=3", state); end
    tx_enable = 1'b1; prefill_level = 11'd100;
    cyc();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL drain_resume state=%0d want=2", state); end
    pops = 0; sample_tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (out_valid !== 1'b1 || out_tdata !== exp_data) errs++;
    end
    total++; if (errs !== 0 || pops !== 5) begin bad++; $display("FAIL b2b_ticks errs=%0d pops=%0d want 0/5", errs, pops); end
    rst_n = 1'b0;
    #2;
    total++; if (fifo_tready !== 1'b0) begin bad++; $display("FAIL midrun_tready got=%b want=0", fifo_tready); end
    cyc();
    total++;
    if (state !== 2'd0 || out_valid !== 1'b0 || cnt !== 15) begin
      bad++; $display("FAIL midrun_reset state=%0d valid=%b cnt=%0d want 0/0/15", state, out_valid, cnt);
    end
    sample_tick = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; pops = 0; rd_ptr = 32'h0000_1000; cnt = 0;
    rst_n = 1'b0; tx_enable = 1'b0; sample_tick = 1'b0; prefill_level = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_prefill();
    test_underrun();
    test_drain_tail();
    test_drain_empty();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
